// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gfx_pkg
// Purpose  : Shared pixel/coordinate widths, transparency key and movement
//            state type for the sprite graphics path.
// Revision : 1.0 - initial release
// ============================================================================
package gfx_pkg;

  localparam int PIX_W   = 6;
  localparam int COORD_W = 10;

  localparam logic [PIX_W-1:0] TRANSPARENT_KEY = 6'b110011;

  typedef enum logic [1:0] {
    MV_IDLE   = 2'd0,
    MV_RUN    = 2'd1,
    MV_BOUNCE = 2'd2,
    MV_HIT    = 2'd3
  } movement_state;

  function automatic logic is_opaque(input logic [PIX_W-1:0] px);
    return px != TRANSPARENT_KEY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// ============================================================================
// Module   : pipe_delay
// Purpose  : Resettable WIDTH-bit shift register, DEPTH stages deep.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor
// Purpose  : N-layer sprite compositor: box test, scaled/flipped ROM address,
//            priority select over background and per-frame collision flags.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_compositor
  import gfx_pkg::*;
#(
  parameter int NUM_SPR  = 2,
  parameter int ADDR_W   = 14,
  parameter int ROM_LAT  = 1,
  parameter int SCALE_SH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                col,
  input  logic [9:0]                row,
  input  logic                      valid_in,
  input  logic                      frame_tick,
  input  logic [NUM_SPR-1:0]        spr_en,
  input  logic [NUM_SPR*10-1:0]     spr_x,
  input  logic [NUM_SPR*10-1:0]     spr_y,
  input  logic [NUM_SPR*7-1:0]      spr_w,
  input  logic [NUM_SPR*7-1:0]      spr_h,
  input  logic [NUM_SPR-1:0]        spr_flip,
  input  logic [NUM_SPR*11-1:0]     anim_row,
  input  logic [NUM_SPR*11-1:0]     anim_col,
  input  logic [NUM_SPR*8-1:0]      stride,
  output logic [NUM_SPR*ADDR_W-1:0] spr_addr,
  input  logic [NUM_SPR*6-1:0]      spr_data,
  input  logic [5:0]                bg_data,
  output logic [5:0]                rgb_out,
  output logic                      valid_out,
  output logic [NUM_SPR-1:0]        collide
);

  localparam int c_FLAG_W = NUM_SPR + 1;

  logic [10:0]               w_col;
  logic [10:0]               w_row;
  logic [NUM_SPR-1:0]        w_inside;
  logic [NUM_SPR*ADDR_W-1:0] w_addr_nx;
  logic [c_FLAG_W-1:0]       w_flags_al;
  logic [NUM_SPR-1:0]        w_inside_al;
  logic                      w_valid_al;
  logic [NUM_SPR-1:0]        w_opaque;
  logic [NUM_SPR-1:0]        w_hit;
  logic [PIX_W-1:0]          w_px;

  logic [NUM_SPR*ADDR_W-1:0] r_spr_addr;
  logic [PIX_W-1:0]          r_rgb;
  logic                      r_valid;
  logic [NUM_SPR-1:0]        r_collide;
  logic [NUM_SPR-1:0]        r_acc;

  // 11-bit compares keep x + scaled size from wrapping at the screen edge.
  assign w_col = {1'b0, col};
  assign w_row = {1'b0, row};

  for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_spr
    logic [10:0] w_x, w_y, w_wv, w_wsz, w_hsz, w_lr, w_lc, w_lcp;
    logic [18:0] w_line;

    assign w_x   = {1'b0, spr_x[gi*COORD_W +: COORD_W]};
    assign w_y   = {1'b0, spr_y[gi*COORD_W +: COORD_W]};
    assign w_wv  = {4'b0, spr_w[gi*7 +: 7]};
    assign w_wsz = w_wv << SCALE_SH;
    assign w_hsz = {4'b0, spr_h[gi*7 +: 7]} << SCALE_SH;

    assign w_inside[gi] = spr_en[gi]
                       && (w_col >= w_x) && (w_col < w_x + w_wsz)
                       && (w_row >= w_y) && (w_row < w_y + w_hsz);

    assign w_lr  = (w_row - w_y) >> SCALE_SH;
    assign w_lc  = (w_col - w_x) >> SCALE_SH;
    assign w_lcp = spr_flip[gi] ? (w_wv - 11'd1 - w_lc) : w_lc;

    assign w_line = 19'(w_lr) + 19'(anim_row[gi*11 +: 11]);
    assign w_addr_nx[gi*ADDR_W +: ADDR_W] = w_inside[gi]
        ? ADDR_W'(w_line * 19'(stride[gi*8 +: 8]) + 19'(w_lcp)
                  + 19'(anim_col[gi*11 +: 11]))
        : '0;
  end

  // One extra stage beyond the ROM covers the address register.
  pipe_delay #(
    .WIDTH (c_FLAG_W),
    .DEPTH (ROM_LAT + 1)
  ) u_flag_dly (
    .clk    (clk),
    .rst    (rst),
    .i_din  ({valid_in, w_inside}),
    .o_dout (w_flags_al)
  );

  assign w_inside_al = w_flags_al[NUM_SPR-1:0];
  assign w_valid_al  = w_flags_al[NUM_SPR];

  always_comb begin
    w_opaque = '0;
    w_hit    = '0;
    w_px     = bg_data;
    for (int i = 0; i < NUM_SPR; i++) begin
      w_opaque[i] = w_inside_al[i] && w_valid_al
                 && is_opaque(spr_data[i*PIX_W +: PIX_W]);
    end
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (w_opaque[i]) w_px = spr_data[i*PIX_W +: PIX_W];
    end
    for (int i = 0; i < NUM_SPR; i++) begin
      w_hit[i] = w_opaque[i] && ((w_opaque & ~(NUM_SPR'(1) << i)) != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spr_addr <= '0;
      r_rgb      <= '0;
      r_valid    <= 1'b0;
      r_collide  <= '0;
      r_acc      <= '0;
    end else begin
      r_spr_addr <= w_addr_nx;
      r_rgb      <= w_valid_al ? w_px : '0;
      r_valid    <= w_valid_al;
      // A hit coincident with the tick seeds the next frame's accumulator.
      if (frame_tick) begin
        r_collide <= r_acc;
        r_acc     <= w_hit;
      end else begin
        r_acc     <= r_acc | w_hit;
      end
    end
  end

  assign spr_addr  = r_spr_addr;
  assign rgb_out   = r_rgb;
  assign valid_out = r_valid;
  assign collide   = r_collide;

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_compositor
// Purpose  : Scoreboard bench driving ROM_LAT=1 and ROM_LAT=3 compositors
//            with shared coordinates and an ideal ROM/background model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;
  import gfx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [9:0] col, row;
  logic       valid_in, ft1, ft3;
  logic [1:0] en, flip, key_mode;
  logic [9:0] sx [2], sy [2];
  logic [6:0] sw [2], sh [2];
  logic [10:0] ar [2], ac [2];
  logic [7:0] st [2];

  logic [19:0] spr_x_v, spr_y_v;
  logic [13:0] spr_w_v, spr_h_v;
  logic [21:0] ar_v, ac_v;
  logic [15:0] st_v;
  assign spr_x_v = {sx[1], sx[0]};
  assign spr_y_v = {sy[1], sy[0]};
  assign spr_w_v = {sw[1], sw[0]};
  assign spr_h_v = {sh[1], sh[0]};
  assign ar_v    = {ar[1], ar[0]};
  assign ac_v    = {ac[1], ac[0]};
  assign st_v    = {st[1], st[0]};

  logic [27:0] addr1, addr3;
  logic [11:0] data1, data3;
  logic [5:0]  bg1, bg3, rgb1, rgb3;
  logic        vo1, vo3;
  logic [1:0]  collide1, collide3;

  int checks = 0;
  int failures = 0;
  logic [6:0] q1 [$];
  logic [6:0] q3 [$];

  function automatic logic [5:0] rom_val(input int i, input logic [13:0] a);
    logic [5:0] v;
    if (key_mode[i]) return TRANSPARENT_KEY;
    v = a[5:0] ^ ((i == 0) ? 6'h05 : 6'h2A);
    if (v == TRANSPARENT_KEY) v = 6'h00;
    return v;
  endfunction

  function automatic logic [5:0] bgf(input logic [9:0] c, input logic [9:0] r);
    return {c[2:0], r[2:0]};
  endfunction

  function automatic int model_addr(input int i, input int c, input int r);
    int x, y, w, h, lr, lc;
    x = int'(sx[i]); y = int'(sy[i]); w = int'(sw[i]); h = int'(sh[i]);
    if (!en[i] || c < x || c >= x + 2 * w || r < y || r >= y + 2 * h) return -1;
    lr = (r - y) / 2;
    lc = (c - x) / 2;
    if (flip[i]) lc = w - 1 - lc;
    return ((lr + int'(ar[i])) * int'(st[i]) + lc + int'(ac[i])) % 16384;
  endfunction

  function automatic logic [6:0] model_px(input logic [9:0] c, input logic [9:0] r, input logic v);
    logic [5:0] px, d;
    int a;
    if (!v) return 7'h00;
    px = bgf(c, r);
    for (int i = 1; i >= 0; i--) begin
      a = model_addr(i, int'(c), int'(r));
      if (a >= 0) begin
        d = rom_val(i, 14'(a));
        if (d != TRANSPARENT_KEY) px = d;
      end
    end
    return {1'b1, px};
  endfunction

  // Ideal ROMs and caller-side background alignment
  logic [5:0] rom1_q [2];
  logic [5:0] rom3_q [2][3];
  logic [5:0] bgp [4];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rom1_q[i]    <= rom_val(i, addr1[i*14 +: 14]);
      rom3_q[i][0] <= rom_val(i, addr3[i*14 +: 14]);
      rom3_q[i][1] <= rom3_q[i][0];
      rom3_q[i][2] <= rom3_q[i][1];
    end
    bgp[0] <= bgf(col, row);
    bgp[1] <= bgp[0];
    bgp[2] <= bgp[1];
    bgp[3] <= bgp[2];
  end
  assign data1 = {rom1_q[1], rom1_q[0]};
  assign data3 = {rom3_q[1][2], rom3_q[0][2]};
  assign bg1   = bgp[1];
  assign bg3   = bgp[3];

  sprite_compositor #(.NUM_SPR(2), .ADDR_W(14), .ROM_LAT(1), .SCALE_SH(1)) dut1 (
    .clk(clk), .rst(rst), .col(col), .row(row), .valid_in(valid_in),
    .frame_tick(ft1), .spr_en(en), .spr_x(spr_x_v), .spr_y(spr_y_v),
    .spr_w(spr_w_v), .spr_h(spr_h_v), .spr_flip(flip), .anim_row(ar_v),
    .anim_col(ac_v), .stride(st_v), .spr_addr(addr1), .spr_data(data1),
    .bg_data(bg1), .rgb_out(rgb1), .valid_out(vo1), .collide(collide1));

  sprite_compositor #(.NUM_SPR(2), .ADDR_W(14), .ROM_LAT(3), .SCALE_SH(1)) dut3 (
    .clk(clk), .rst(rst), .col(col), .row(row), .valid_in(valid_in),
    .frame_tick(ft3), .spr_en(en), .spr_x(spr_x_v), .spr_y(spr_y_v),
    .spr_w(spr_w_v), .spr_h(spr_h_v), .spr_flip(flip), .anim_row(ar_v),
    .anim_col(ac_v), .stride(st_v), .spr_addr(addr3), .spr_data(data3),
    .bg_data(bg3), .rgb_out(rgb3), .valid_out(vo3), .collide(collide3));

  // Drives one pixel, records its expected output, and hands back any entry now due.
  task automatic step(input logic [9:0] c, input logic [9:0] r, input logic v,
                      input logic t1, input logic t3,
                      output logic d1, output logic [6:0] e1, output logic [6:0] g1,
                      output logic d3, output logic [6:0] e3, output logic [6:0] g3);
    col = c; row = r; valid_in = v; ft1 = t1; ft3 = t3;
    q1.push_back(model_px(c, r, v));
    q3.push_back(model_px(c, r, v));
    @(posedge clk); #1;
    d1 = (q1.size() == 3);
    e1 = d1 ? q1.pop_front() : 7'h00;
    g1 = {vo1, rgb1};
    d3 = (q3.size() == 5);
    e3 = d3 ? q3.pop_front() : 7'h00;
    g3 = {vo3, rgb3};
  endtask

  task automatic test_reset();
    rst = 1'b1; col = '0; row = '0; valid_in = 1'b0; ft1 = 1'b0; ft3 = 1'b0;
    en = 2'b01; flip = 2'b00; key_mode = 2'b00;
    sx[0] = 10'd50;  sy[0] = 10'd290; sw[0] = 7'd23; sh[0] = 7'd30;
    ar[0] = 11'd3;   ac[0] = 11'd5;   st[0] = 8'd40;
    sx[1] = 10'd60;  sy[1] = 10'd300; sw[1] = 7'd10; sh[1] = 7'd10;
    ar[1] = 11'd2;   ac[1] = 11'd1;   st[1] = 8'd16;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rgb1, vo1, collide1, addr1} !== 37'h0) begin
      failures++; $display("FAIL reset_lat1: got=%h required=0", {rgb1, vo1, collide1, addr1});
    end
    checks++;
    if ({rgb3, vo3, collide3, addr3} !== 37'h0) begin
      failures++; $display("FAIL reset_lat3: got=%h required=0", {rgb3, vo3, collide3, addr3});
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_addr();
    int pc [5] = '{50, 96, 95, 60, 49};
    int pr [5] = '{290, 290, 349, 300, 290};
    logic d1, d3; logic [6:0] e1, g1, e3, g3;
    int a; logic [13:0] ea;
    for (int k = 0; k < 11; k++) begin
      if (k < 5) begin
        a = model_addr(0, pc[k], pr[k]);
        ea = (a < 0) ? 14'd0 : 14'(a);
        step(10'(pc[k]), 10'(pr[k]), 1'b1, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
        checks++;
        if (addr1[13:0] !== ea || addr3[13:0] !== ea) begin
          failures++; $display("FAIL addr k=%0d: got=%0d/%0d required=%0d", k, addr1[13:0], addr3[13:0], ea);
        end
        if (k == 0) begin
          checks++;
          if (addr1[13:0] !== 14'd125) begin
            failures++; $display("FAIL addr_origin: got=%0d required=125", addr1[13:0]);
          end
        end
      end else begin
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      end
      if (d1) begin
        checks++;
        if (g1 !== e1) begin failures++; $display("FAIL addr_px_lat1 k=%0d: got=%h required=%h", k, g1, e1); end
      end
      if (d3) begin
        checks++;
        if (g3 !== e3) begin failures++; $display("FAIL addr_px_lat3 k=%0d: got=%h required=%h", k, g3, e3); end
      end
    end
  endtask

  task automatic test_flip();
    int pc [4] = '{50, 51, 95, 52};
    int pr [4] = '{290, 290, 290, 291};
    logic [13:0] lit [2] = '{14'd147, 14'd147};
    logic d1, d3; logic [6:0] e1, g1, e3, g3;
    int a;
    flip = 2'b01;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        a = model_addr(0, pc[k], pr[k]);
        step(10'(pc[k]), 10'(pr[k]), 1'b1, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
        checks++;
        if (addr1[13:0] !== 14'(a)) begin
          failures++; $display("FAIL flip_addr k=%0d: got=%0d required=%0d", k, addr1[13:0], a);
        end
        if (k < 2) begin
          checks++;
          if (addr1[13:0] !== lit[k]) begin
            failures++; $display("FAIL flip_addr_lit k=%0d: got=%0d required=%0d", k, addr1[13:0], lit[k]);
          end
        end
      end else begin
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      end
      if (d1) begin
        checks++;
        if (g1 !== e1) begin failures++; $display("FAIL flip_px_lat1 k=%0d: got=%h required=%h", k, g1, e1); end
      end
      if (d3) begin
        checks++;
        if (g3 !== e3) begin failures++; $display("FAIL flip_px_lat3 k=%0d: got=%h required=%h", k, g3, e3); end
      end
    end
    flip = 2'b00;
  endtask

  task automatic test_priority();
    int pc [7] = '{65, 70, 79, 55, 80, 200, 64};
    int pr [7] = '{305, 310, 319, 295, 320, 200, 305};
    logic vv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic d1, d3; logic [6:0] e1, g1, e3, g3;
    en = 2'b11;
    for (int km = 0; km < 4; km++) begin
      key_mode = 2'(km);
      for (int k = 0; k < 13; k++) begin
        if (k < 7) step(10'(pc[k]), 10'(pr[k]), vv[k], 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
        else       step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
        if (d1) begin
          checks++;
          if (g1 !== e1) begin failures++; $display("FAIL prio_lat1 km=%0d k=%0d: got=%h required=%h", km, k, g1, e1); end
        end
        if (d3) begin
          checks++;
          if (g3 !== e3) begin failures++; $display("FAIL prio_lat3 km=%0d k=%0d: got=%h required=%h", km, k, g3, e3); end
        end
      end
    end
    key_mode = 2'b00;
  endtask

  task automatic test_latency();
    logic d1, d3; logic [6:0] e1, g1, e3, g3;
    int first1 = -1, first3 = -1;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) step(10'd65, 10'd305, 1'b1, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      else        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      if (first1 < 0 && vo1) first1 = k;
      if (first3 < 0 && vo3) first3 = k;
    end
    checks++;
    if (first1 != 2) begin failures++; $display("FAIL latency_lat1: got=%0d edges required=3", first1 + 1); end
    checks++;
    if (first3 != 4) begin failures++; $display("FAIL latency_lat3: got=%0d edges required=5", first3 + 1); end
  endtask

  task automatic test_collision();
    logic d1, d3; logic [6:0] e1, g1, e3, g3;
    en = 2'b11; key_mode = 2'b00;
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, d1, e1, g1, d3, e3, g3);
    // frame k: opaque overlap
    for (int k = 0; k < 9; k++) begin
      if (k < 3) step(10'(65 + k), 10'(305 + k), 1'b1, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      else       step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
    end
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, d1, e1, g1, d3, e3, g3);
    checks++;
    if (collide1 !== 2'b11 || collide3 !== 2'b11) begin
      failures++; $display("FAIL collide_overlap: got=%b/%b required=11", collide1, collide3);
    end
    // frame k+1: sprites apart
    sx[1] = 10'd300; sy[1] = 10'd100;
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      step(10'd65, 10'd305, 1'b1, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      else if (k == 1) step(10'd305, 10'd105, 1'b1, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      else             step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
    end
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, d1, e1, g1, d3, e3, g3);
    checks++;
    if (collide1 !== 2'b00 || collide3 !== 2'b00) begin
      failures++; $display("FAIL collide_apart: got=%b/%b required=00", collide1, collide3);
    end
    // hit lands on the tick cycle of each pipeline
    sx[1] = 10'd60; sy[1] = 10'd300;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) step(10'd65, 10'd305, 1'b1, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      else        step(10'd0, 10'd0, 1'b0, k == 2, k == 4, d1, e1, g1, d3, e3, g3);
    end
    checks++;
    if (collide1 !== 2'b00 || collide3 !== 2'b00) begin
      failures++; $display("FAIL collide_on_tick_now: got=%b/%b required=00", collide1, collide3);
    end
    repeat (3) step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, d1, e1, g1, d3, e3, g3);
    checks++;
    if (collide1 !== 2'b11 || collide3 !== 2'b11) begin
      failures++; $display("FAIL collide_on_tick_next: got=%b/%b required=11", collide1, collide3);
    end
  endtask

  task automatic test_reset_mid();
    logic d1, d3; logic [6:0] e1, g1, e3, g3;
    for (int k = 0; k < 5; k++) step(10'(62 + k), 10'd305, 1'b1, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rgb3, vo3, collide3, addr3} !== 37'h0) begin
      failures++; $display("FAIL reset_mid_lat3: got=%h required=0", {rgb3, vo3, collide3, addr3});
    end
    checks++;
    if ({rgb1, vo1, collide1, addr1} !== 37'h0) begin
      failures++; $display("FAIL reset_mid_lat1: got=%h required=0", {rgb1, vo1, collide1, addr1});
    end
    @(posedge clk); #3;
    rst = 1'b0;
    q1.delete(); q3.delete();
    for (int k = 0; k < 12; k++) begin
      if (k < 6) step(10'(64 + k), 10'(304 + k), 1'b1, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      else       step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, d1, e1, g1, d3, e3, g3);
      if (!d3) begin
        checks++;
        if (g3 !== 7'h00) begin failures++; $display("FAIL refill_lat3 k=%0d: got=%h required=00", k, g3); end
      end
      if (d1) begin
        checks++;
        if (g1 !== e1) begin failures++; $display("FAIL resume_lat1 k=%0d: got=%h required=%h", k, g1, e1); end
      end
      if (d3) begin
        checks++;
        if (g3 !== e3) begin failures++; $display("FAIL resume_lat3 k=%0d: got=%h required=%h", k, g3, e3); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr();
    test_flip();
    test_priority();
    test_latency();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
